// File: rtl/seg_scan_decoder_if.sv
// Scan-bus observation interface: the multiplexed 7-segment bus plus the decoded frame results.
// The master drives the display scan; the slave is the decoder that watches it.
interface seg_scan_decoder_if;
    logic [7:0]  seg;
    logic [2:0]  which;
    logic [31:0] value;
    logic        value_valid;
    logic        value_changed;
    logic [7:0]  digit_mask;
    logic        bad_pattern;
    logic        stale;

    modport master (
        output seg, which,
        input  value, value_valid, value_changed, digit_mask, bad_pattern, stale
    );

    modport slave (
        input  seg, which,
        output value, value_valid, value_changed, digit_mask, bad_pattern, stale
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Watches the multiplexed 8-digit 7-segment scan and rebuilds the 32-bit hex value shown,
// filtering inter-digit glitches, flagging undecodable patterns and detecting stalled scans.
module seg_scan_decoder #(
    parameter int STABLE_CYC     = 4,
    parameter int TIMEOUT_CYC    = 4096,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               rst,
    seg_scan_decoder_if.slave bus
);
    localparam int RW = $clog2(STABLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [9:0]      smp;
    logic [9:0]      smp_d;
    logic [RW-1:0]   run;
    logic            accepted;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0][3:0] digits;
    logic            have_frame;
    logic [31:0]     value;
    logic            value_valid;
    logic            value_changed;
    logic            bad_pattern;
    logic            stale;
    logic [7:0]      digit_mask;
    logic [7:0]      mask_nxt;
    logic [6:0]      lit;
    logic [2:0]      wsel;
    logic [3:0]      nib;
    logic            nib_ok;
    logic            accept;
    logic            complete;
    logic            timeout;
    logic            unused_dp;

    assign smp_d     = {bus.seg[6:0], bus.which};
    assign unused_dp = bus.seg[7];
    assign lit       = SEG_ACTIVE_LOW ? ~smp[9:3] : smp[9:3];
    assign wsel      = smp[2:0];

    // run counts consecutive identical samples held in smp; one accept per dwell
    assign accept   = (run == RW'(STABLE_CYC)) && !accepted;
    assign complete = (digit_mask == 8'hFF);
    assign timeout  = !accept && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        nib    = 4'h0;
        nib_ok = 1'b1;
        case (lit)
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: nib_ok = 1'b0;
        endcase
    end

    // A completed frame clears the mask first, so a coincident accept starts the next frame
    always_comb begin
        mask_nxt = (complete || timeout) ? 8'h00 : digit_mask;
        if (accept) mask_nxt[wsel] = nib_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp           <= '0;
            run           <= '0;
            accepted      <= 1'b0;
            tmo_cnt       <= '0;
            digits        <= '0;
            have_frame    <= 1'b0;
            value         <= '0;
            value_valid   <= 1'b0;
            value_changed <= 1'b0;
            bad_pattern   <= 1'b0;
            stale         <= 1'b0;
            digit_mask    <= '0;
        end else begin
            smp <= smp_d;
            if (smp_d != smp) begin
                run      <= RW'(1);
                accepted <= 1'b0;
            end else begin
                if (run != RW'(STABLE_CYC)) run <= run + RW'(1);
                if (accept) accepted <= 1'b1;
            end

            if (accept || timeout) tmo_cnt <= '0;
            else                   tmo_cnt <= tmo_cnt + TW'(1);

            if (accept && nib_ok) digits[wsel] <= nib;
            digit_mask    <= mask_nxt;
            bad_pattern   <= accept && !nib_ok;
            value_valid   <= complete;
            value_changed <= complete && (!have_frame || (digits != value));

            if (complete) begin
                value      <= digits;
                have_frame <= 1'b1;
                stale      <= 1'b0;
            end else if (timeout) begin
                stale <= 1'b1;
            end
        end
    end

    assign bus.value         = value;
    assign bus.value_valid   = value_valid;
    assign bus.value_changed = value_changed;
    assign bus.digit_mask    = digit_mask;
    assign bus.bad_pattern   = bad_pattern;
    assign bus.stale         = stale;
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Observer on the multiplexed 7-segment scan bus (seg, which) that the ALU display logic drives.
- Rebuilds the 32-bit hex value shown on the 8-digit display.
- Lets bench/BIST logic check ALU results in-circuit, without reading internal registers.
- Handles scan dwell, glitches between digits, undecodable patterns and stalled scanning.

Parameters:
- STABLE_CYC, 4: consecutive identical samples of {seg,which} required before a digit is accepted (min 2).
- TIMEOUT_CYC, 4096: cycles with no accepted digit before the partial frame is discarded.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when seg bit is 0.

Ports:
- clk  in  1  system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- seg  in  8  segment bus; seg[0]=a … seg[6]=g, seg[7]=dp (ignored).
- which  in  3  digit currently driven; 0 = least-significant nibble.
- value  out  32  last complete frame; digit k in value[4k+3:4k].
- value_valid  out  1  one-cycle pulse when value updates.
- value_changed  out  1  one-cycle pulse, coincident with value_valid, when the new value differs from the previous one.
- digit_mask  out  8  digits captured in the current partial frame.
- bad_pattern  out  1  one-cycle pulse when an accepted sample is undecodable.
- stale  out  1  level; set on timeout, cleared on next completed frame.

Behaviour:
- Reset: all outputs 0; digit registers, stability counter, timeout counter and the accepted flag cleared. Reset mid-frame discards the partial frame.
- Stage 1: {seg[6:0],which} registered every cycle as smp.
- Stability counter:
  - Cleared when smp differs from the previous smp; otherwise increments, saturating.
  - accept fires on the edge where smp has been unchanged for STABLE_CYC consecutive samples.
  - accept fires once per dwell: an accepted flag blocks repeats until smp changes.
- Decode: lit = SEG_ACTIVE_LOW ? ~seg[6:0] : seg[6:0]. Codes 0..F map from lit =
  - 0–7: 3F 06 5B 4F 66 6D 7D 07
  - 8–F: 7F 6F 77 7C 39 5E 79 71
- Valid accept: write nibble to digit[which]; set digit_mask[which]. Rewriting an already-set digit overwrites it.
- Invalid accept: pulse bad_pattern; clear digit_mask[which].
- Frame complete: on the cycle after digit_mask becomes 8'hFF:
  - value <= assembled digits; value_valid = 1.
  - value_changed = (new value != old value); also 1 on the first frame after reset.
  - digit_mask <= 0; stale <= 0.
  - An accept in that same cycle applies to the freshly cleared mask.
- Latency: stable input → digit written STABLE_CYC+1 edges after the input changes; last digit → value_valid 1 edge later.
- Timeout: counter cleared on every accept, else increments. At TIMEOUT_CYC: digit_mask <= 0, stale <= 1, counter restarts. value is held.
- Scan order is free; out-of-order or repeated digits are legal.

Test Plan:
- ALU 5+3: scan digits 0..7 at 10 cycles each, digit0 seg=8'h80, others 8'hC0 → one value_valid, value=32'h00000008, value_changed=1, digit_mask back to 0.
- Repeat the identical frame → value_valid=1, value_changed=0, value unchanged.
- Glitch: insert 3-cycle seg=8'hF9 on which=2 between dwells (STABLE_CYC=4) → no accept, bad_pattern=0, frame value still 32'h00000008.
- Blank digit: hold seg=8'hFF on which=5 for 10 cycles → bad_pattern pulses once, digit_mask[5]=0, no value_valid until which=5 is re-shown validly.
- Stall: after 3 digits hold which=3 with a constant valid pattern for TIMEOUT_CYC cycles → stale=1, digit_mask=0. A later complete frame clears stale.
- Reset mid-frame: assert rst after digits 0..5 → all outputs 0. Then scan only digits 6,7 → no value_valid.
